// File: rtl/multicycle_ctrl.sv
// FSM control unit for the multicycle TinyRV1 core: decodes the latched instruction, arbitrates
// the shared memory port between fetch and LW/SW, and sequences the iterative multiplier.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        eq,
  input  logic        mul_done,
  input  logic        mem_req_rdy,
  input  logic        mem_resp_val,
  output logic        mem_req_val,
  output logic        mem_req_wr,
  output logic        mem_addr_sel,
  output logic        ir_en,
  output logic [1:0]  imm_type,
  output logic        alu_bsel,
  output logic        mul_start,
  output logic        rf_wen,
  output logic [1:0]  wb_sel,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        retire,
  output logic        illegal
);

  typedef enum logic [3:0] {
    StFetch, StFwait, StDecode, StExec, StMulw, StMem, StMwait, StWb, StHalt
  } state_e;

  typedef enum logic [3:0] {
    OpAdd, OpAddi, OpMul, OpLw, OpSw, OpJal, OpJr, OpBne, OpIll
  } op_e;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  op_e        op;
  logic [1:0] imm_sel;
  logic       rd_nz;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_rs1;

  assign opcode     = inst[6:0];
  assign funct3     = inst[14:12];
  assign funct7     = inst[31:25];
  assign rd_nz      = |inst[11:7];
  assign unused_rs1 = ^inst[19:15];

  always_comb begin
    op = OpIll;
    case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) op = OpAdd;
        else if (funct3 == 3'b000 && funct7 == 7'b0000001) op = OpMul;
      end
      7'b0010011: if (funct3 == 3'b000) op = OpAddi;
      7'b0000011: if (funct3 == 3'b010) op = OpLw;
      7'b0100011: if (funct3 == 3'b010) op = OpSw;
      7'b1101111: op = OpJal;
      // JR is JALR restricted to rd=x0 and a zero offset
      7'b1100111: if (funct3 == 3'b000 && !rd_nz && inst[31:20] == 12'h000) op = OpJr;
      7'b1100011: if (funct3 == 3'b001) op = OpBne;
      default: op = OpIll;
    endcase
  end

  always_comb begin
    case (op)
      OpSw:    imm_sel = 2'd1;
      OpJal:   imm_sel = 2'd2;
      OpBne:   imm_sel = 2'd3;
      default: imm_sel = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    mem_req_val  = 1'b0;
    mem_req_wr   = 1'b0;
    mem_addr_sel = 1'b0;
    ir_en        = 1'b0;
    imm_type     = 2'd0;
    alu_bsel     = 1'b0;
    mul_start    = 1'b0;
    rf_wen       = 1'b0;
    wb_sel       = 2'd0;
    pc_en        = 1'b0;
    pc_sel       = 2'd0;

    if (state_q inside {StDecode, StExec, StMulw, StMem, StMwait, StWb}) imm_type = imm_sel;

    case (state_q)
      StFetch: begin
        mem_req_val = 1'b1;
        if (mem_req_rdy) state_d = StFwait;
      end
      StFwait: begin
        if (mem_resp_val) begin
          ir_en   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (op == OpIll) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (op)
          OpAdd:  state_d = StWb;
          OpAddi: begin
            alu_bsel = 1'b1;
            state_d  = StWb;
          end
          OpMul: begin
            mul_start = 1'b1;
            state_d   = StMulw;
          end
          OpLw, OpSw: begin
            alu_bsel = 1'b1;
            state_d  = StMem;
          end
          OpJal: begin
            rf_wen  = rd_nz;
            wb_sel  = 2'd3;
            pc_sel  = 2'd1;
            pc_en   = 1'b1;
            state_d = StFetch;
          end
          OpJr: begin
            pc_sel  = 2'd2;
            pc_en   = 1'b1;
            state_d = StFetch;
          end
          OpBne: begin
            pc_sel  = eq ? 2'd0 : 2'd1;
            pc_en   = 1'b1;
            state_d = StFetch;
          end
          default: state_d = StHalt;
        endcase
      end
      StMulw: begin
        if (mul_done) state_d = StWb;
      end
      StMem: begin
        mem_req_val  = 1'b1;
        mem_addr_sel = 1'b1;
        mem_req_wr   = (op == OpSw);
        alu_bsel     = 1'b1;
        if (mem_req_rdy) state_d = StMwait;
      end
      StMwait: begin
        if (mem_resp_val) begin
          if (op == OpSw) begin
            pc_en   = 1'b1;
            state_d = StFetch;
          end else begin
            wb_sel  = 2'd2;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_wen  = rd_nz;
        wb_sel  = (op == OpMul) ? 2'd1 : (op == OpLw) ? 2'd2 : 2'd0;
        pc_en   = 1'b1;
        state_d = StFetch;
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase

    // Reset asserted mid-instruction must not leak a partial RF/PC write or memory request
    if (!rst_n) begin
      mem_req_val  = 1'b0;
      mem_req_wr   = 1'b0;
      mem_addr_sel = 1'b0;
      ir_en        = 1'b0;
      imm_type     = 2'd0;
      alu_bsel     = 1'b0;
      mul_start    = 1'b0;
      rf_wen       = 1'b0;
      wb_sel       = 2'd0;
      pc_en        = 1'b0;
      pc_sel       = 2'd0;
    end
  end

  assign retire  = pc_en;
  assign illegal = illegal_q & rst_n;

endmodule
